// File: rtl/key_led_pkg.sv
// rtl/key_led_pkg.sv - shared types and defaults for the key/LED controller
package key_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } key_state_e;

    localparam longint unsigned HOLD_TH_DEF = 64'h0A98AC7;
    localparam int unsigned     DEB_CYC_DEF = 50000;
    localparam int unsigned     REP_PER_DEF = 4000000;

    localparam logic KEY_PRESSED = 1'b0;

endpackage

// File: rtl/key_led_chan.sv
// rtl/key_led_chan.sv - one key channel: sync, debounce, press classifier, LED toggle
// Optional auto-repeat while a long press is held: KEY_LED_AUTOREP_EN
module key_led_chan
    import key_led_pkg::*;
#(
    parameter int unsigned     CNT_W   = 25,
    parameter longint unsigned HOLD_TH = HOLD_TH_DEF,
    parameter int unsigned     DEB_W   = 16,
    parameter int unsigned     DEB_CYC = DEB_CYC_DEF,
    parameter int unsigned     REP_PER = REP_PER_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic led,
    output logic short_pulse,
    output logic long_pulse,
    output logic long_hold
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_TH);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    if (REP_PER == 0) begin : g_bad_rep
        $error("REP_PER must be at least 1");
    end

    logic [1:0]       sync_q, sync_d;
    logic             deb_lvl_q, deb_lvl_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
    logic             led_q, led_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             long_hold_q, long_hold_d;
    logic             key_s, press_evt, rel_evt;

`ifdef KEY_LED_AUTOREP_EN
    localparam int unsigned      REP_W    = $clog2(REP_PER + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_PER);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
`endif

    assign key_s = sync_q[1];

    always_comb begin
        sync_d    = {sync_q[0], key_n};
        deb_lvl_d = deb_lvl_q;
        deb_cnt_d = deb_cnt_q;
        if (key_s == deb_lvl_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_lvl_d = key_s;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // The FSM reacts on the same edge the debounced level flips.
    assign press_evt = (deb_lvl_d != deb_lvl_q) && (deb_lvl_d == KEY_PRESSED);
    assign rel_evt   = (deb_lvl_d != deb_lvl_q) && (deb_lvl_d != KEY_PRESSED);
    assign hold_inc  = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        led_d       = led_q;
        short_d     = 1'b0;
        long_d      = 1'b0;
        long_hold_d = 1'b0;
`ifdef KEY_LED_AUTOREP_EN
        rep_cnt_d   = rep_cnt_q;
        rep_inc     = rep_cnt_q + 1'b1;
`endif
        case (state_q)
            ST_IDLE: begin
                if (press_evt) begin
                    state_d    = ST_PRESSED;
                    hold_cnt_d = '0;
                end
            end
            ST_PRESSED: begin
                hold_cnt_d = hold_inc;
                if (rel_evt) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                    led_d   = ~led_q;
                end else if (hold_inc == HOLD_LIM) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
`ifdef KEY_LED_AUTOREP_EN
                    rep_cnt_d = '0;
`endif
                end
            end
            ST_LONG: begin
                if (rel_evt) begin
                    state_d = ST_IDLE;
                end else begin
                    long_hold_d = 1'b1;
`ifdef KEY_LED_AUTOREP_EN
                    if (rep_inc == REP_LAST) begin
                        rep_cnt_d = '0;
                        short_d   = 1'b1;
                        led_d     = ~led_q;
                    end else begin
                        rep_cnt_d = rep_inc;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b11;
            deb_lvl_q   <= ~KEY_PRESSED;
            deb_cnt_q   <= '0;
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            led_q       <= 1'b1;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            long_hold_q <= 1'b0;
`ifdef KEY_LED_AUTOREP_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            sync_q      <= sync_d;
            deb_lvl_q   <= deb_lvl_d;
            deb_cnt_q   <= deb_cnt_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            led_q       <= led_d;
            short_q     <= short_d;
            long_q      <= long_d;
            long_hold_q <= long_hold_d;
`ifdef KEY_LED_AUTOREP_EN
            rep_cnt_q   <= rep_cnt_d;
`endif
        end
    end

    assign led         = led_q;
    assign short_pulse = short_q;
    assign long_pulse  = long_q;
    assign long_hold   = long_hold_q;

endmodule

// File: rtl/key_led_ctrl.sv
// rtl/key_led_ctrl.sv - N independent debounced key channels with short/long press and LED toggle
// Optional auto-repeat while a long press is held: KEY_LED_AUTOREP_EN
module key_led_ctrl
    import key_led_pkg::*;
#(
    parameter int unsigned     N_KEYS  = 4,
    parameter int unsigned     CNT_W   = 25,
    parameter longint unsigned HOLD_TH = HOLD_TH_DEF,
    parameter int unsigned     DEB_W   = 16,
    parameter int unsigned     DEB_CYC = DEB_CYC_DEF,
    parameter int unsigned     REP_PER = REP_PER_DEF
) (
    input  logic              FPGA_clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] led,
    output logic [N_KEYS-1:0] short_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] long_hold
);

    if (CNT_W < 64 && HOLD_TH >= (64'd1 << CNT_W)) begin : g_bad_hold
        $error("HOLD_TH does not fit in CNT_W bits");
    end

    if (DEB_CYC < 2) begin : g_bad_deb
        $error("DEB_CYC must be at least 2");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_led_chan #(
            .CNT_W   (CNT_W),
            .HOLD_TH (HOLD_TH),
            .DEB_W   (DEB_W),
            .DEB_CYC (DEB_CYC),
            .REP_PER (REP_PER)
        ) u_chan (
            .clk         (FPGA_clk),
            .rst         (rst),
            .key_n       (key_n[i]),
            .led         (led[i]),
            .short_pulse (short_pulse[i]),
            .long_pulse  (long_pulse[i]),
            .long_hold   (long_hold[i])
        );
    end

endmodule

// File: tb/tb_key_led_ctrl.sv
// tb/tb_key_led_ctrl.sv - scoreboard bench for key_led_ctrl (2 keys, short debounce/hold settings)
module tb_key_led_ctrl;

    localparam int N_KEYS  = 2;
    localparam int DEB_CYC = 4;
    localparam int HOLD_TH = 20;
    localparam int REP_PER = 8;
    localparam int LAT     = 2 + DEB_CYC;

    localparam int EV_SHORT = 0;
    localparam int EV_LONG  = 1;
    localparam int EV_RISE  = 2;
    localparam int EV_FALL  = 3;

    typedef struct {
        int kind;
        int cyc;
        int led;
    } ev_t;

    logic              clk;
    logic              rst;
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] led;
    logic [N_KEYS-1:0] short_pulse;
    logic [N_KEYS-1:0] long_pulse;
    logic [N_KEYS-1:0] long_hold;

    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    logic              mon_en = 1'b0;
    logic [N_KEYS-1:0] hold_prev = '0;
    logic [N_KEYS-1:0] led_m = '1;
    ev_t               ev_q[N_KEYS][$];

    key_led_ctrl #(
        .N_KEYS  (N_KEYS),
        .CNT_W   (25),
        .HOLD_TH (HOLD_TH),
        .DEB_W   (16),
        .DEB_CYC (DEB_CYC),
        .REP_PER (REP_PER)
    ) dut (
        .FPGA_clk    (clk),
        .rst         (rst),
        .key_n       (key_n),
        .led         (led),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .long_hold   (long_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_ev(input int ch, input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.led  = int'(led_m[ch]);
        ev_q[ch].push_back(e);
    endtask

    // Long press from debounced press dp until end_cyc (debounced release or reset).
    task automatic push_long_part(input int ch, input int dp, input int end_cyc, input bit by_reset);
        push_ev(ch, EV_LONG, dp + HOLD_TH);
        push_ev(ch, EV_RISE, dp + HOLD_TH + 1);
`ifdef KEY_LED_AUTOREP_EN
        for (int t = dp + HOLD_TH + REP_PER; t < end_cyc; t += REP_PER) begin
            led_m[ch] = ~led_m[ch];
            push_ev(ch, EV_SHORT, t);
        end
`endif
        if (by_reset) led_m = '1;
        push_ev(ch, EV_FALL, end_cyc);
    endtask

    // Key driven low at cycle p and high again at cycle r.
    task automatic push_press(input int ch, input int p, input int r);
        int dp, dr;
        dp = p + LAT;
        dr = r + LAT;
        if (dr - dp <= HOLD_TH) begin
            led_m[ch] = ~led_m[ch];
            push_ev(ch, EV_SHORT, dr);
        end else begin
            push_long_part(ch, dp, dr, 1'b0);
        end
    endtask

    task automatic observe(input int ch, input int kind);
        ev_t e;
        if (ev_q[ch].size() == 0) begin
            check_eq($sformatf("unexpected_ev_ch%0d", ch), kind, -1);
        end else begin
            e = ev_q[ch].pop_front();
            check_eq($sformatf("ev_kind_ch%0d", ch), kind, e.kind);
            check_eq($sformatf("ev_cyc_ch%0d", ch), cyc, e.cyc);
            check_eq($sformatf("ev_led_ch%0d", ch), int'(led[ch]), e.led);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int ch = 0; ch < N_KEYS; ch++) begin
                while (ev_q[ch].size() != 0 && ev_q[ch][0].cyc < cyc) begin
                    check_eq($sformatf("missed_ev_ch%0d", ch), cyc, ev_q[ch][0].cyc);
                    void'(ev_q[ch].pop_front());
                end
                if (short_pulse[ch] && long_pulse[ch])
                    check_eq($sformatf("pulse_excl_ch%0d", ch), 1, 0);
                if (short_pulse[ch]) observe(ch, EV_SHORT);
                if (long_pulse[ch]) observe(ch, EV_LONG);
                if (long_hold[ch] && !hold_prev[ch]) observe(ch, EV_RISE);
                if (!long_hold[ch] && hold_prev[ch]) observe(ch, EV_FALL);
                hold_prev[ch] = long_hold[ch];
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int p, m;
        rst   = 1'b1;
        key_n = '1;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_led", int'(led), 3);
        check_eq("rst_short", int'(short_pulse), 0);
        check_eq("rst_long", int'(long_pulse), 0);
        check_eq("rst_hold", int'(long_hold), 0);
        mon_en = 1'b1;
        step(50);
        check_eq("idle_led", int'(led), 3);

        // Excursion shorter than the debounce window
        key_n[0] = 1'b0;
        step(3);
        key_n[0] = 1'b1;
        step(20);
        check_eq("glitch_led0", int'(led[0]), 1);
        check_eq("glitch_noev", ev_q[0].size(), 0);

        // Two identical short presses on key 0
        for (int k = 0; k < 2; k++) begin
            push_press(0, cyc, cyc + 10);
            key_n[0] = 1'b0;
            step(10);
            key_n[0] = 1'b1;
            step(20);
        end
        check_eq("short2_led0", int'(led[0]), 1);

        // Long press on key 1
        push_press(1, cyc, cyc + 60);
        key_n[1] = 1'b0;
        step(60);
        key_n[1] = 1'b1;
        step(20);

        // Both keys on the same cycle: key 0 short, key 1 long
        push_press(0, cyc, cyc + 10);
        push_press(1, cyc, cyc + 40);
        key_n = '0;
        step(10);
        key_n[0] = 1'b1;
        step(30);
        key_n[1] = 1'b1;
        step(20);
        check_eq("both_led", int'(led), int'(led_m));

        // Reset while key 0 is in a long press, key kept held through and after reset
        p = cyc;
        push_long_part(0, p + LAT, p + 40, 1'b1);
        key_n[0] = 1'b0;
        step(40);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_led", int'(led), 3);
        check_eq("midrst_short", int'(short_pulse), 0);
        check_eq("midrst_long", int'(long_pulse), 0);
        check_eq("midrst_hold", int'(long_hold), 0);
        step(2);
        rst = 1'b0;
        m = cyc;
        push_long_part(0, m + LAT, m + 40 + LAT, 1'b0);
        step(40);
        key_n[0] = 1'b1;
        step(20);

        check_eq("end_led", int'(led), int'(led_m));
        for (int ch = 0; ch < N_KEYS; ch++)
            check_eq($sformatf("end_pending_ch%0d", ch), ev_q[ch].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_led_ctrl.md
Name: key_led_ctrl

Overview:
Multi-channel successor to the single-key long-press counter and LED toggle pair. Each channel does the following:
- synchronises and debounces one active-low push button
- classifies each press as short or long
- toggles an LED on a short press
Sits between board buttons and LED pins; pulse outputs also feed other control logic.

Parameters:
N_KEYS, 4, number of independent key/LED channels
CNT_W, 25, width of per-channel hold counter
HOLD_TH, 25'h0A98AC7, hold-counter value at which a press becomes long
DEB_W, 16, width of debounce counter
DEB_CYC, 50000, consecutive stable cycles required to accept a new key level (>=2)
REP_PER, 4000000, auto-repeat period in cycles (used only with the optional feature)

Ports:
FPGA_clk     input   1        system clock, all logic on rising edge
rst          input   1        asynchronous, active-high reset
key_n        input   N_KEYS   raw buttons, 0 = pressed
led          output  N_KEYS   LED drive, registered
short_pulse  output  N_KEYS   1-cycle pulse per accepted short press
long_pulse   output  N_KEYS   1-cycle pulse when a press becomes long
long_hold    output  N_KEYS   level, high while a long press is held

Behaviour:
- Reset (async assert, sync use): sync flops=1, debounced level=released, debounce cnt=0, hold cnt=0, state=IDLE, led=all 1, short_pulse/long_pulse/long_hold=0.
- Channels are fully independent; no shared state; simultaneous activity on all channels is legal.
- Sync: 2-FF synchroniser per key_n bit.
- Debounce: counter clears whenever sync output equals debounced level. Otherwise it increments. When it reaches DEB_CYC-1 and the next sample still differs, the debounced level updates and the counter clears.
- Debounce latency: raw edge to debounced change = 2 + DEB_CYC cycles. Any excursion shorter than DEB_CYC stable cycles is ignored.
- FSM per channel: IDLE, PRESSED, LONG.
  - IDLE: debounced press -> PRESSED, hold cnt <= 0.
  - PRESSED: hold cnt += 1 per cycle.
    - hold cnt == HOLD_TH -> LONG; long_pulse=1 for that one cycle.
    - Debounced release before that -> IDLE; short_pulse=1 for one cycle; led toggles on the same edge.
    - Release and threshold in the same cycle: release wins (short press).
  - LONG: long_hold=1 (registered, first high cycle = the cycle after long_pulse). Debounced release -> IDLE, long_hold=0 next cycle, no short_pulse, led unchanged.
- Hold cnt saturates at all-ones (never wraps); it is cleared on entry to PRESSED.
- HOLD_TH must be < 2^CNT_W; this is checked by an elaboration assertion.
- Reset mid-press: everything returns to reset values. If the key is still held, it is seen as a new press after 2 + DEB_CYC cycles.
- short_pulse and long_pulse are never both high on one channel in the same cycle.

Optional Feature:
KEY_LED_AUTOREP_EN
- Defined: in LONG, a repeat counter (cleared on entry to LONG) emits short_pulse and toggles led every REP_PER cycles while held. The first repeat comes REP_PER cycles after long_pulse.
- Undefined: no repeat counter exists; LONG emits nothing after long_pulse; REP_PER is unused.

Decomposition:
- Package key_led_pkg: FSM state enum (IDLE/PRESSED/LONG), default values of HOLD_TH/DEB_CYC/REP_PER, KEY_PRESSED=1'b0 constant.
- Sub-module key_led_chan: one channel (sync, debounce, FSM, hold/repeat counters, LED flop). The top instantiates N_KEYS copies in a generate loop.

Test Plan (N_KEYS=2, DEB_CYC=4, HOLD_TH=20, REP_PER=8):
- Reset then idle 50 cycles -> led=2'b11, all pulses and long_hold stay 0.
- key_n[0] low for 3 cycles, then high -> debounced level never changes, no pulses, led[0]=1.
- key_n[0] low 10 cycles, then high -> exactly one short_pulse[0] at 2+4 cycles after the rising edge; led[0] 1->0; second identical press -> led[0] back to 1.
- key_n[1] low 60 cycles -> long_pulse[1] once, 20 cycles after debounced press; long_hold[1] high from next cycle until 1 cycle after debounced release; no short_pulse[1]; led[1] unchanged. With KEY_LED_AUTOREP_EN: short_pulse[1] every 8 cycles after long_pulse, led[1] toggling each time.
- Both keys pressed on the same cycle, key 0 short and key 1 long -> each channel produces its own scenario result with no cross-talk.
- rst pulsed while key_n[0] held in LONG -> outputs at reset values immediately; with the key still held, a new PRESSED entry occurs 6 cycles after rst deasserts.
